servo_move_sequencer: RTL and testbench

SERVO_MOVE_SEQUENCER -- requirements
Module: servo_move_sequencer

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_cmd_fifo.sv | 61 ++++++
 rtl/servo_move_sequencer.sv | 126 ++++++++++++
 tb/tb_servo_move_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and widths for the servo move sequencer.
// Holds the FSM state encoding and the queued command record.
package servo_pkg;

    localparam int POS_W = 16;
    localparam int CMD_W = 2 * POS_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_WAIT,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] target;
        logic [POS_W-1:0] prescale;
    } cmd_t;

endpackage

// File: rtl/servo_cmd_fifo.sv
// Synchronous command queue with flush, level, full and empty.
// Flush has priority over a same-edge push or pop.
module servo_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since level guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// Queues move commands and feeds them one at a time to the speed
// controller, tracking committed position and a per-move timeout.
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [POS_W-1:0]  HOME_POS   = 16'd0,
    parameter logic [31:0]       TIMEOUT    = 32'd1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [POS_W-1:0]              cmd_target,
    input  logic [POS_W-1:0]              cmd_prescale,
    input  logic                          abort,
    input  logic                          clear_fault,
    output logic [POS_W-1:0]              start_pos,
    output logic [POS_W-1:0]              end_pos,
    output logic [POS_W-1:0]              prescale,
    output logic                          go,
    input  logic                          ssc_done,
    output logic                          move_done,
    output logic                          busy,
    output logic                          fault,
    output logic [POS_W-1:0]              cur_pos,
    output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

    state_t      state;
    logic [31:0] count;
    cmd_t        wcmd;
    cmd_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        flush;
    logic        timeout_hit;

    assign wcmd        = '{target: cmd_target, prescale: cmd_prescale};
    assign cmd_ready   = !fifo_full && (state != S_FAULT);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == S_IDLE) && !fifo_empty && !abort;
    assign timeout_hit = (state == S_WAIT) && !ssc_done
                         && (count == TIMEOUT - 32'd1);
    assign flush       = abort || timeout_hit;
    assign busy        = (state != S_IDLE) || !fifo_empty;

    servo_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wcmd),
        .rdata (head),
        .level (queue_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Move sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            cur_pos   <= HOME_POS;
            start_pos <= HOME_POS;
            end_pos   <= HOME_POS;
            prescale  <= '0;
            go        <= 1'b0;
            move_done <= 1'b0;
            fault     <= 1'b0;
        end else begin
            go        <= 1'b0;
            move_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        state     <= S_LOAD;
                        start_pos <= cur_pos;
                        end_pos   <= head.target;
                        prescale  <= head.prescale;
                    end
                end
                S_LOAD: begin
                    if (end_pos != start_pos) begin
                        state <= S_GO;
                        go    <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        move_done <= 1'b1;
                    end
                end
                S_GO: begin
                    state <= S_WAIT;
                    count <= '0;
                end
                S_WAIT: begin
                    if (ssc_done) begin
                        state     <= S_IDLE;
                        cur_pos   <= end_pos;
                        move_done <= 1'b1;
                    end else if (timeout_hit) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state <= S_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Self-checking bench for servo_move_sequencer: table-driven moves,
// directed corner sequences and a randomized scoreboard phase.
module tb_servo_move_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_target = '0;
    logic [15:0] cmd_prescale = '0;
    logic        abort = 1'b0;
    logic        clear_fault = 1'b0;
    logic [15:0] start_pos;
    logic [15:0] end_pos;
    logic [15:0] prescale;
    logic        go;
    logic        ssc_done;
    logic        move_done;
    logic        busy;
    logic        fault;
    logic [15:0] cur_pos;
    logic [2:0]  queue_level;

    logic        man_pulse = 1'b0;
    logic        auto_pulse = 1'b0;
    assign ssc_done = man_pulse | auto_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] t;
        logic [15:0] p;
    } rec_t;

    rec_t        exp_q[$];
    bit          sb_en = 1'b0;
    bit          auto_done = 1'b0;
    bit          inflight = 1'b0;
    logic [15:0] itarget = '0;
    logic [15:0] mpos = '0;
    int          moves = 0;
    int          skips = 0;

    always #5 clk = ~clk;

    servo_move_sequencer #(
        .FIFO_DEPTH (4),
        .HOME_POS   (16'd0),
        .TIMEOUT    (32'(TO))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_prescale (cmd_prescale),
        .abort        (abort),
        .clear_fault  (clear_fault),
        .start_pos    (start_pos),
        .end_pos      (end_pos),
        .prescale     (prescale),
        .go           (go),
        .ssc_done     (ssc_done),
        .move_done    (move_done),
        .busy         (busy),
        .fault        (fault),
        .cur_pos      (cur_pos),
        .queue_level  (queue_level)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Offer a command until accepted; w returns cycles spent stalled.
    task automatic push_cmd(input logic [15:0] t, input logic [15:0] p,
                            output int w);
        rec_t r;
        w = 0;
        cmd_target   = t;
        cmd_prescale = p;
        cmd_valid    = 1'b1;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("push_timeout", 0, 1);
        r.t = t;
        r.p = p;
        if (sb_en) exp_q.push_back(r);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_go(input int max);
        int n = 0;
        while (!go && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_go", go, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_busy", busy, 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_cur_pos", cur_pos, 0);
        chk("rst_start", start_pos, 0);
        chk("rst_end", end_pos, 0);
        chk("rst_prescale", prescale, 0);
        chk("rst_go", go, 0);
        chk("rst_move_done", move_done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", queue_level, 0);
        chk("rst_ready", cmd_ready, 1);
    endtask

    // Scoreboard: commands must come out in order; each is a move
    // when its target differs from the committed position, else a skip.
    initial begin
        rec_t c;
        forever begin
            @(negedge clk);
            if (sb_en && go) begin
                if (exp_q.size() == 0) begin
                    chk("sb_go_unexpected", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    chk("sb_move_not_skip", 32'(c.t != mpos), 1);
                    chk("sb_start_pos", start_pos, mpos);
                    chk("sb_end_pos", end_pos, c.t);
                    chk("sb_prescale", prescale, c.p);
                    inflight = 1'b1;
                    itarget  = c.t;
                end
            end
            if (sb_en && move_done) begin
                if (inflight) begin
                    mpos     = itarget;
                    inflight = 1'b0;
                    moves++;
                    chk("sb_cur_pos", cur_pos, mpos);
                end else if (exp_q.size() == 0) begin
                    chk("sb_done_unexpected", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    skips++;
                    chk("sb_skip_target", c.t, mpos);
                end
            end
        end
    end

    // Speed-controller stand-in: answers each go after a short delay.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && go) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                auto_pulse = 1'b1;
                @(negedge clk);
                auto_pulse = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] target;
        logic [15:0] pre;
        bit          exp_go;
        logic [15:0] exp_start;
        logic [15:0] exp_cur;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w;
        int m0;
        int s0;
        int n;
        int mdc;
        int goc;
        logic [15:0] tsel [4];

        vecs[0] = '{16'd127,    16'd5,      1'b1, 16'd0,      16'd127};
        vecs[1] = '{16'd127,    16'd9,      1'b0, 16'd127,    16'd127};
        vecs[2] = '{16'hFFFF,   16'd1,      1'b1, 16'd127,    16'hFFFF};
        vecs[3] = '{16'd0,      16'h1234,   1'b1, 16'hFFFF,   16'd0};
        vecs[4] = '{16'd0,      16'd3,      1'b0, 16'd0,      16'd0};
        vecs[5] = '{16'd300,    16'd0,      1'b1, 16'd0,      16'd300};
        tsel[0] = 16'd0;
        tsel[1] = 16'd50;
        tsel[2] = 16'd100;
        tsel[3] = 16'hFFFF;

        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Single moves and zero-length skips from the table.
        for (int i = 0; i < 6; i++) begin
            push_cmd(vecs[i].target, vecs[i].pre, w);
            @(negedge clk);
            chk("load_go_low", go, 0);
            @(negedge clk);
            chk("start_pos", start_pos, vecs[i].exp_start);
            chk("end_pos", end_pos, vecs[i].target);
            if (vecs[i].exp_go) begin
                chk("go_at_k2", go, 1);
                chk("prescale", prescale, vecs[i].pre);
                chk("no_early_done", move_done, 0);
                @(negedge clk);
                chk("go_one_cycle", go, 0);
                man_pulse = 1'b1;
                @(negedge clk);
                man_pulse = 1'b0;
                chk("move_done", move_done, 1);
                chk("cur_pos", cur_pos, vecs[i].exp_cur);
            end else begin
                chk("skip_no_go", go, 0);
                chk("skip_done", move_done, 1);
                chk("skip_cur_pos", cur_pos, vecs[i].exp_cur);
            end
            @(negedge clk);
            chk("done_one_cycle", move_done, 0);
        end
        mpos = 16'd300;

        // Full queue behind a move in progress: fifth push stalls.
        sb_en = 1'b1;
        m0 = moves;
        push_cmd(16'd1000, 16'd7, w);
        wait_go(10);
        for (int i = 0; i < 4; i++) begin
            push_cmd(16'(2000 + i), 16'(i), w);
        end
        cmd_target   = 16'd2004;
        cmd_prescale = 16'd4;
        cmd_valid    = 1'b1;
        chk("full_ready_low", cmd_ready, 0);
        chk("full_level", queue_level, 4);
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        chk("full_ready_idle", cmd_ready, 0);
        auto_done = 1'b1;
        push_cmd(16'd2004, 16'd4, w);
        chk("stall_cycles", w, 1);
        wait_idle(500);
        chk("burst_moves", moves - m0, 6);
        chk("burst_queue_empty", exp_q.size(), 0);

        // Randomized traffic against the scoreboard.
        m0 = moves;
        s0 = skips;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_cmd(tsel[$urandom_range(0, 3)], 16'($urandom), w);
        end
        wait_idle(3000);
        chk("rand_all_retired", (moves - m0) + (skips - s0), 60);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_level", queue_level, 0);
        sb_en = 1'b0;
        auto_done = 1'b0;
        @(negedge clk);

        // Timeout: go falls, WAIT spans TO cycles, then FAULT.
        push_cmd(mpos + 16'd1, 16'd2, w);
        wait_go(10);
        n = 0;
        push_cmd(mpos + 16'd2, 16'd2, w);
        n++;
        push_cmd(mpos + 16'd3, 16'd2, w);
        n++;
        chk("to_level_before", queue_level, 2);
        while (!fault && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fault_latency", n, TO + 1);
        chk("fault_flushed", queue_level, 0);
        chk("fault_cur_pos", cur_pos, mpos);
        chk("fault_ready", cmd_ready, 0);
        chk("fault_busy", busy, 1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fault_push_ignored", queue_level, 0);
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        chk("fault_done_ignored", fault, 1);
        chk("fault_no_move_done", move_done, 0);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        chk("fault_cleared", fault, 0);
        chk("clear_idle", busy, 0);
        chk("clear_ready", cmd_ready, 1);

        // Abort during WAIT: queue flushed, current move finishes.
        push_cmd(mpos + 16'd10, 16'd1, w);
        push_cmd(mpos + 16'd20, 16'd1, w);
        push_cmd(mpos + 16'd30, 16'd1, w);
        wait_go(10);
        @(negedge clk);
        chk("abort_level_before", queue_level, 2);
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_target = mpos + 16'd40;
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_flushed", queue_level, 0);
        man_pulse = 1'b1;
        mdc = 0;
        goc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            man_pulse = 1'b0;
            mdc += int'(move_done);
            goc += int'(go);
        end
        chk("abort_one_done", mdc, 1);
        chk("abort_no_go", goc, 0);
        chk("abort_cur_pos", cur_pos, mpos + 16'd10);
        mpos = mpos + 16'd10;

        // Stray ssc_done while IDLE changes nothing.
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        chk("stray_no_done", move_done, 0);
        chk("stray_cur_pos", cur_pos, mpos);

        // Reset in the middle of a move.
        push_cmd(mpos + 16'd5, 16'd6, w);
        wait_go(10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        mdc = 0;
        goc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mdc += int'(move_done);
            goc += int'(go);
        end
        chk("post_rst_no_done", mdc, 0);
        chk("post_rst_no_go", goc, 0);
        push_cmd(16'd7, 16'd1, w);
        repeat (2) @(negedge clk);
        chk("post_rst_go", go, 1);
        chk("post_rst_start", start_pos, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
